// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline stall/flush controller for a pipeline whose instruction and data
//   memory ports can respond in different cycles. The FSM remembers which
//   response already arrived, so the pipeline advances only once both
//   outstanding requests are satisfied. It then applies load-use stalls and
//   flushes on top of that advance.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_read/imem_resp instruction port request / one-cycle response
//   dmem_read/dmem_write/dmem_resp  data port request / one-cycle response
//   load_use_stall      load-use hazard in ID
//   flush               taken branch / redirect this cycle
//   load[STAGES]        per pipeline register load enable (0 = IF/ID)
//   bubble[STAGES]      per pipeline register NOP insert (valid with load)
//   load_pc             PC load enable
//   imem_mask           instruction response already captured, do not reissue
//   stall_count         consecutive stalled cycles (saturating)
//   stall_timeout       sticky watchdog flag
//   dbg_state           current FSM state, for observation only
//
// Handshake: a memory request is open while its *_read/*_write is high. It
//   is satisfied by a single-cycle *_resp pulse. When both ports are open, the
//   pipeline advances in the cycle the later of the two responses arrives.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int STAGES      = 4,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              imem_read,
  input  logic              imem_resp,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic              dmem_resp,
  input  logic              load_use_stall,
  input  logic              flush,
  output logic [STAGES-1:0] load,
  output logic [STAGES-1:0] bubble,
  output logic              load_pc,
  output logic              imem_mask,
  output logic [CNT_W-1:0]  stall_count,
  output logic              stall_timeout,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] WAIT_D = 2'd1; // instruction response captured
  localparam logic [1:0] WAIT_I = 2'd2; // data response captured

  localparam logic [STAGES-1:0] ALL_ONES   = {STAGES{1'b1}};
  localparam logic [STAGES-1:0] FLUSH_MASK = STAGES'((1 << FLUSH_DEPTH) - 1);
  localparam logic [STAGES-1:0] LUS_LOAD   = ALL_ONES & ~STAGES'(1);
  localparam logic [STAGES-1:0] LUS_BUBBLE = STAGES'(2);
  localparam logic [CNT_W-1:0]  TIMEOUT_V  = CNT_W'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             d_req;
  logic             advance;
  logic             adv_out;

  assign d_req = dmem_read | dmem_write;

  // Advance decision and next-state.
  always_comb begin
    advance = 1'b1;
    state_d = state_q;
    case (state_q)
      WAIT_D: begin
        advance = dmem_resp;
        if (dmem_resp) state_d = RUN;
      end
      WAIT_I: begin
        advance = imem_resp;
        if (imem_resp) state_d = RUN;
      end
      default: begin
        state_d = RUN;
        if (imem_read && d_req) begin
          advance = imem_resp & dmem_resp;
          if (imem_resp && !dmem_resp) state_d = WAIT_D;
          if (dmem_resp && !imem_resp) state_d = WAIT_I;
        end else if (imem_read) begin
          advance = imem_resp;
        end else if (d_req) begin
          advance = dmem_resp;
        end else begin
          advance = 1'b1;
        end
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign adv_out = advance & rst_n;

  // Flush beats load-use; both are ignored when not advancing because the
  // datapath keeps presenting them until the advance cycle.
  always_comb begin
    load    = '0;
    bubble  = '0;
    load_pc = 1'b0;
    if (adv_out) begin
      if (flush) begin
        load    = ALL_ONES;
        bubble  = FLUSH_MASK;
        load_pc = 1'b1;
      end else if (load_use_stall) begin
        load    = LUS_LOAD;
        bubble  = LUS_BUBBLE;
        load_pc = 1'b0;
      end else begin
        load    = ALL_ONES;
        bubble  = '0;
        load_pc = 1'b1;
      end
    end
  end

  assign imem_mask = rst_n & (state_q == WAIT_D);

  // Saturating stall counter and sticky watchdog.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (advance) begin
      cnt_d = '0;
    end else begin
      if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d >= TIMEOUT_V) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_count   = cnt_q;
  assign stall_timeout = timeout_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed bench. Two instances share all inputs: dut uses default
//   parameters, dut_wd uses CNT_W=3, TIMEOUT=5 for the watchdog scenario.
//   Inputs change 1 time unit after the rising edge. Combinational outputs
//   are checked 2 units later, and registered outputs 1 unit after the edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
  logic       load_use_stall, flush;
  logic [3:0] load, bubble;
  logic       load_pc, imem_mask, stall_timeout;
  logic [7:0] stall_count;
  logic [1:0] dbg_state;
  logic [3:0] load_w, bubble_w;
  logic       load_pc_w, imem_mask_w, stall_timeout_w;
  logic [2:0] stall_count_w;
  logic [1:0] dbg_state_w;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_WAIT_D = 2'd1;
  localparam logic [1:0] S_WAIT_I = 2'd2;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .load_use_stall(load_use_stall), .flush(flush),
    .load(load), .bubble(bubble), .load_pc(load_pc), .imem_mask(imem_mask),
    .stall_count(stall_count), .stall_timeout(stall_timeout),
    .dbg_state(dbg_state)
  );

  pipe_hazard_ctrl #(.CNT_W(3), .TIMEOUT(5)) dut_wd (
    .clk(clk), .rst_n(rst_n),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .load_use_stall(load_use_stall), .flush(flush),
    .load(load_w), .bubble(bubble_w), .load_pc(load_pc_w),
    .imem_mask(imem_mask_w),
    .stall_count(stall_count_w), .stall_timeout(stall_timeout_w),
    .dbg_state(dbg_state_w)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ir, input logic irs, input logic dr,
                       input logic drs, input logic lus, input logic fl);
    imem_read      = ir;
    imem_resp      = irs;
    dmem_read      = dr;
    dmem_write     = 1'b0;
    dmem_resp      = drs;
    load_use_stall = lus;
    flush          = fl;
    #2;
  endtask

  // Finish the current cycle: clock edge, then 1 unit of settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_comb(input string tag, input logic [3:0] e_load,
                            input logic [3:0] e_bub, input logic e_pc);
    check({tag, ".load"}, 32'(load), 32'(e_load));
    check({tag, ".bubble"}, 32'(bubble), 32'(e_bub));
    check({tag, ".load_pc"}, 32'(load_pc), 32'(e_pc));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset state.
    check_comb("rst", 4'b0000, 4'b0000, 1'b0);
    check("rst.mask", 32'(imem_mask), 32'd0);
    check("rst.cnt", 32'(stall_count), 32'd0);
    check("rst.tmo", 32'(stall_timeout), 32'd0);
    check("rst.state", 32'(dbg_state), 32'(S_RUN));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Idle: no requests means advance.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_comb("idle", 4'b1111, 4'b0000, 1'b1);
    tick();

    // Fetch only: 3 stall cycles, then response.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_comb("fetch.stall", 4'b0000, 4'b0000, 1'b0);
      tick();
      check("fetch.cnt", 32'(stall_count), 32'(i));
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_comb("fetch.adv", 4'b1111, 4'b0000, 1'b1);
    tick();
    check("fetch.cnt0", 32'(stall_count), 32'd0);

    // Split response: I at cycle 2, D at cycle 5.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);          // cycle 1
    check_comb("split.c1", 4'b0000, 4'b0000, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);          // cycle 2
    check_comb("split.c2", 4'b0000, 4'b0000, 1'b0);
    check("split.c2.mask", 32'(imem_mask), 32'd0);
    tick();
    check("split.c3.state", 32'(dbg_state), 32'(S_WAIT_D));
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);          // cycle 3
    check("split.c3.mask", 32'(imem_mask), 32'd1);
    check_comb("split.c3", 4'b0000, 4'b0000, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);          // cycle 4, stray I resp
    check("split.c4.mask", 32'(imem_mask), 32'd1);
    check_comb("split.c4", 4'b0000, 4'b0000, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);          // cycle 5
    check("split.c5.mask", 32'(imem_mask), 32'd1);
    check_comb("split.c5", 4'b1111, 4'b0000, 1'b1);
    tick();
    check("split.end.state", 32'(dbg_state), 32'(S_RUN));
    check("split.end.cnt", 32'(stall_count), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("split.end.mask", 32'(imem_mask), 32'd0);
    tick();

    // Load-use ignored while stalled.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_comb("hold.nadv", 4'b0000, 4'b0000, 1'b0);
    tick();
    // Load-use on an advance cycle, then clean advance.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_comb("lus", 4'b1110, 4'b0010, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_comb("lus.next", 4'b1111, 4'b0000, 1'b1);
    tick();
    // Flush with and without load-use.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_comb("flush.lus", 4'b1111, 4'b0111, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_comb("flush", 4'b1111, 4'b0111, 1'b1);
    tick();

    // WAIT_I via early D response.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_comb("wi.enter", 4'b0000, 4'b0000, 1'b0);
    tick();
    check("wi.state", 32'(dbg_state), 32'(S_WAIT_I));
    check("wi.mask", 32'(imem_mask), 32'd0);
    // Reset mid-wait, with an I response that would otherwise advance.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_comb("rstw", 4'b0000, 4'b0000, 1'b0);
    check("rstw.state", 32'(dbg_state), 32'(S_RUN));
    check("rstw.mask", 32'(imem_mask), 32'd0);
    check("rstw.cnt", 32'(stall_count), 32'd0);
    tick();
    rst_n = 1'b1;
    // I response alone with D pending must not advance: the latched D is gone.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_comb("rstw.after", 4'b0000, 4'b0000, 1'b0);
    tick();
    check("rstw.after.state", 32'(dbg_state), 32'(S_WAIT_D));
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_comb("rstw.finish", 4'b1111, 4'b0000, 1'b1);
    tick();

    // Watchdog on the CNT_W=3, TIMEOUT=5 instance.
    check("wd.tmo0", 32'(stall_timeout_w), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check("wd.cnt", 32'(stall_count_w), 32'((i > 7) ? 7 : i));
      check("wd.tmo", 32'(stall_timeout_w), 32'((i >= 5) ? 1 : 0));
    end
    check("wd.dflt.cnt", 32'(stall_count), 32'd9);
    check("wd.dflt.tmo", 32'(stall_timeout), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("wd.adv.load", 32'(load_w), 32'hF);
    tick();
    check("wd.adv.cnt", 32'(stall_count_w), 32'd0);
    check("wd.adv.tmo", 32'(stall_timeout_w), 32'd1);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
Parameters (name, default, meaning):
REQ-001 STAGES, 4, number of pipeline registers; index 0 = IF/ID, STAGES-1 = MEM/WB; legal range 2..8.
REQ-002 FLUSH_DEPTH, 3, number of youngest pipeline registers bubbled on a flush; legal range 1..STAGES-1.
REQ-003 CNT_W, 8, width of the consecutive-stall counter.
REQ-004 TIMEOUT, 200, consecutive-stall count that raises stall_timeout; must be below 2^CNT_W.

Ports (name, direction, width, meaning):
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 imem_read  in  1  instruction port request active.
REQ-008 imem_resp  in  1  instruction port response, valid for one cycle.
REQ-009 dmem_read, dmem_write  in  1 each  data port request active; d_req = dmem_read | dmem_write.
REQ-010 dmem_resp  in  1  data port response, valid for one cycle.
REQ-011 load_use_stall  in  1  load-use hazard detected in ID.
REQ-012 flush  in  1  taken branch or redirect resolved this cycle.
REQ-013 load  out  STAGES  per-register load enable.
REQ-014 bubble  out  STAGES  per-register NOP insert; meaningful only where load is 1.
REQ-015 load_pc  out  1  PC register load enable.
REQ-016 imem_mask  out  1  instruction request already satisfied; the cache must not re-issue it.
REQ-017 stall_count  out  CNT_W  current consecutive-stall cycle count.
REQ-018 stall_timeout  out  1  sticky watchdog flag.

Function
REQ-019 The FSM SHALL have states RUN, WAIT_D (I response latched) and WAIT_I (D response latched).
REQ-020 In RUN, advance SHALL equal: imem_resp & dmem_resp when imem_read & d_req; imem_resp when imem_read only; dmem_resp when d_req only; 1 when neither is active.
REQ-021 In RUN with imem_read & d_req, imem_resp=1 and dmem_resp=0 SHALL transition to WAIT_D, and dmem_resp=1 with imem_resp=0 SHALL transition to WAIT_I; all other cases stay in RUN.
REQ-022 In WAIT_D, advance SHALL equal dmem_resp, and the FSM SHALL return to RUN on the advance cycle; imem_resp SHALL be ignored; imem_mask SHALL be 1.
REQ-023 In WAIT_I, advance SHALL equal imem_resp, and the FSM SHALL return to RUN on the advance cycle; dmem_resp SHALL be ignored.
REQ-024 When advance=0, load, bubble and load_pc SHALL all be 0.
REQ-025 When advance=1 with no hazard: load SHALL be all 1s, bubble all 0s, and load_pc 1.
REQ-026 When advance=1 and load_use_stall=1 and flush=0: load[0]=0 and load_pc=0; load[STAGES-1:1] all 1; bubble[1]=1; all other bubble bits 0.
REQ-027 When advance=1 and flush=1: load all 1s, load_pc=1, bubble[FLUSH_DEPTH-1:0] all 1s; load_use_stall SHALL be ignored (flush has priority).
REQ-028 flush or load_use_stall asserted while advance=0 SHALL have no effect; the datapath holds them until advance.
REQ-029 stall_count SHALL increment on each advance=0 cycle, saturate at 2^CNT_W-1, and clear to 0 on any advance=1 cycle.
REQ-030 stall_timeout SHALL set on the edge where stall_count reaches TIMEOUT and remain 1 until reset.
REQ-031 Every output except stall_count and stall_timeout SHALL be combinational from state and inputs, with no added latency.

Reset
REQ-032 While rst_n=0: state=RUN, stall_count=0, stall_timeout=0, imem_mask=0, and load/bubble/load_pc forced to 0, asynchronously.
REQ-033 A reset asserted in WAIT_D or WAIT_I SHALL discard the latched response immediately.
REQ-034 After rst_n deasserts, operation SHALL resume on the first rising clk edge in RUN.

Verification
REQ-035 Fetch only: imem_read=1; imem_resp low for 3 cycles, then high -> load=0000 for 3 cycles, then load=1111 and load_pc=1; stall_count 1,2,3 then 0.
REQ-036 Split response: imem_read=dmem_read=1; imem_resp at cycle 2, dmem_resp at cycle 5 -> WAIT_D from cycle 3, imem_mask=1 during cycles 3-5, single load=1111 pulse at cycle 5, back to RUN.
REQ-037 Load-use hazard: advance=1 with load_use_stall=1 -> load=1110, bubble=0010, load_pc=0; the next advance with load_use_stall=0 -> load=1111, bubble=0000.
REQ-038 Flush vs load-use: flush=1 and load_use_stall=1 on an advance cycle -> load=1111, bubble=0111, load_pc=1.
REQ-039 Watchdog with TIMEOUT=5, CNT_W=3: d_req held with no response for 9 cycles -> stall_timeout=1 from the 5th stall edge, stall_count saturates at 7, stall_timeout stays 1 after a later advance.
REQ-040 Reset mid-wait: in WAIT_I, drop rst_n for 1 cycle -> state=RUN, all outputs 0 during reset; a later imem_resp alone with d_req active does not advance.
